// File: rtl/link_ch_regs.sv
// link_ch_regs: per-channel register responder behind one link decoder window.
// Holds ID, scratch, control, sticky interrupt status/mask and saturating
// per-event counters; returns read data one cycle after RD_EN.
// Optional build macro LINK_CH_REGS_CLR_ON_RD_EN: reading an EVT_CNT register
// clears that counter on the following cycle (an event in the read cycle
// leaves it at 1).
module link_ch_regs #(
   parameter int          ADDR_W  = 17,
   parameter int          NUM_EVT = 8,
   parameter int          CNT_W   = 48,
   parameter logic [63:0] ID_VAL  = 64'h4C32_0000_0000_0001
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [ADDR_W-1:0]  ADDR,
   input  logic [63:0]        WR_DATA,
   input  logic               WR_EN,
   input  logic               RD_EN,
   output logic [63:0]        RD_DATA,
   output logic               RD_DATA_V,
   input  logic [NUM_EVT-1:0] iEVT,
   output logic [31:0]        oCTRL,
   output logic               oINT
);

   localparam logic [7:0] OFF_ID   = 8'h00;
   localparam logic [7:0] OFF_SCR  = 8'h01;
   localparam logic [7:0] OFF_CTRL = 8'h02;
   localparam logic [7:0] OFF_ST   = 8'h03;
   localparam logic [7:0] OFF_MASK = 8'h04;
   localparam logic [7:0] OFF_CNT  = 8'h10;

   logic [7:0]         off;
   logic               in_win;
   logic [NUM_EVT-1:0] sel_cnt;
   logic               wr_scr, wr_ctrl, wr_st, wr_mask;
   logic               cnt_clr;
   logic [NUM_EVT-1:0] cnt_inc;

   logic [63:0]        scratch_q, scratch_d;
   logic [31:0]        ctrl_q, ctrl_d;
   logic [NUM_EVT-1:0] st_q, st_d;
   logic [NUM_EVT-1:0] mask_q, mask_d;
   logic               int_q, int_d;
   logic [CNT_W-1:0]   cnt_q [NUM_EVT];
   logic [CNT_W-1:0]   cnt_d [NUM_EVT];
   logic [63:0]        rd_data_q, rd_data_d, rd_mux;
   logic               rd_v_q, rd_v_d;

   // Upper address bits select the window upstream; only [13:0] decode here.
   assign off     = ADDR[7:0];
   assign in_win  = (ADDR[13:8] == 6'd0);
   assign wr_scr  = WR_EN & in_win & (off == OFF_SCR);
   assign wr_ctrl = WR_EN & in_win & (off == OFF_CTRL);
   assign wr_st   = WR_EN & in_win & (off == OFF_ST);
   assign wr_mask = WR_EN & in_win & (off == OFF_MASK);
   assign cnt_clr = wr_ctrl & WR_DATA[1];
   assign cnt_inc = {NUM_EVT{ctrl_q[0]}} & iEVT;

   // Decode which event counter (if any) the current address targets.
   always_comb begin
      for (int i = 0; i < NUM_EVT; i++) begin
         sel_cnt[i] = in_win && (off == OFF_CNT + 8'(i));
      end
   end

   // Read mux; anything not decoded returns the DEAD_BEEF tag with the address.
   always_comb begin
      rd_mux                = {32'hDEAD_BEEF, 32'h0};
      rd_mux[ADDR_W-1:0]    = ADDR;
      if (in_win) begin
         case (off)
            OFF_ID:   rd_mux = ID_VAL;
            OFF_SCR:  rd_mux = scratch_q;
            OFF_CTRL: rd_mux = {32'h0, ctrl_q};
            OFF_ST: begin
               rd_mux                = '0;
               rd_mux[NUM_EVT-1:0]   = st_q;
            end
            OFF_MASK: begin
               rd_mux                = '0;
               rd_mux[NUM_EVT-1:0]   = mask_q;
            end
            default: ;
         endcase
         for (int i = 0; i < NUM_EVT; i++) begin
            if (sel_cnt[i]) begin
               rd_mux              = '0;
               rd_mux[CNT_W-1:0]   = cnt_q[i];
            end
         end
      end
   end

   // Next state for control/status registers; a new event beats a same-cycle W1C.
   always_comb begin
      scratch_d = wr_scr  ? WR_DATA : scratch_q;
      ctrl_d    = wr_ctrl ? {WR_DATA[31:2], 1'b0, WR_DATA[0]} : ctrl_q;
      mask_d    = wr_mask ? WR_DATA[NUM_EVT-1:0] : mask_q;
      st_d      = (st_q & ~(wr_st ? WR_DATA[NUM_EVT-1:0] : '0)) | iEVT;
      int_d     = |(st_q & ~mask_q);
      rd_v_d    = RD_EN;
      rd_data_d = RD_EN ? rd_mux : rd_data_q;
   end

   // Counter next state: saturating increment, optional clear-on-read, cnt_clr wins.
   always_comb begin
      for (int i = 0; i < NUM_EVT; i++) begin
         cnt_d[i] = cnt_q[i];
         if (cnt_inc[i] && !(&cnt_q[i])) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
`ifdef LINK_CH_REGS_CLR_ON_RD_EN
         if (RD_EN && sel_cnt[i]) begin
            cnt_d[i] = cnt_inc[i] ? CNT_W'(1) : '0;
         end
`endif
         if (cnt_clr) begin
            cnt_d[i] = '0;
         end
      end
   end

   // Register state; reset also drops any read response still in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scratch_q <= '0;
         ctrl_q    <= '0;
         st_q      <= '0;
         mask_q    <= '1;
         int_q     <= 1'b0;
         rd_data_q <= '0;
         rd_v_q    <= 1'b0;
      end else begin
         scratch_q <= scratch_d;
         ctrl_q    <= ctrl_d;
         st_q      <= st_d;
         mask_q    <= mask_d;
         int_q     <= int_d;
         rd_data_q <= rd_data_d;
         rd_v_q    <= rd_v_d;
      end
   end

   // Event counter storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_EVT; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_EVT; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign RD_DATA   = rd_data_q;
   assign RD_DATA_V = rd_v_q;
   assign oCTRL     = ctrl_q;
   assign oINT      = int_q;

endmodule

// File: doc/link_ch_regs.md
Name: link_ch_regs

Overview:
- Per-channel register responder on the link register bus; sits behind one channel window of the link address decoder (CH0/CH1 slot).
- Accepts registered ADDR/WR_DATA/WR_EN/RD_EN strobes from the decoder and returns RD_DATA/RD_DATA_V.
- Holds ID, scratch, control, sticky interrupt status/mask and per-event saturating counters; drives a channel interrupt.

Parameters:
- ADDR_W, 17, bus address width (64-bit word address).
- NUM_EVT, 8, number of event inputs/counters, legal 1..16.
- CNT_W, 48, event counter width, legal 1..64.
- ID_VAL, 64'h4C32_0000_0000_0001, value returned by the ID register.

Ports:
- clk  in  1  register bus clock.
- rst_n  in  1  asynchronous active-low reset.
- ADDR  in  ADDR_W  word address from decoder.
- WR_DATA  in  64  write data.
- WR_EN  in  1  single-cycle write strobe.
- RD_EN  in  1  single-cycle read strobe.
- RD_DATA  out  64  read data.
- RD_DATA_V  out  1  read data valid pulse.
- iEVT  in  NUM_EVT  per-cycle event pulses, clk domain.
- oCTRL  out  32  CTRL[31:0] to channel datapath, bit1 always 0.
- oINT  out  1  level interrupt.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: RD_DATA=0, RD_DATA_V=0, SCRATCH=0, CTRL=0, INT_STATUS=0, INT_MASK=all ones, all counters=0, oINT=0, oCTRL=0.
- Decode: offset = ADDR[7:0]; ADDR[13:8] must be 0, else unmapped; ADDR[ADDR_W-1:14] ignored (the decoder selects the window).
- Register map (word offsets):
  - 0x00 ID: RO, ID_VAL.
  - 0x01 SCRATCH: RW, 64 bits.
  - 0x02 CTRL: RW. [0] cnt_en. [1] cnt_clr, self-clearing, reads 0. [31:2] RW, passed to oCTRL. [63:32] read 0.
  - 0x03 INT_STATUS: W1C, [NUM_EVT-1:0] sticky; set on any cycle iEVT[i]=1.
  - 0x04 INT_MASK: RW, [NUM_EVT-1:0], 1=masked.
  - 0x10+i EVT_CNT[i]: RO, zero-extended CNT_W, i<NUM_EVT.
- Read: RD_EN at cycle t -> RD_DATA valid and RD_DATA_V=1 at t+1, one cycle only.
  - RD_DATA holds that value until the next read completes, because the decoder samples data independently of valid.
  - Unmapped read returns {32'hDEAD_BEEF,(32-ADDR_W)'b0,ADDR}; RD_DATA_V still pulses.
- Write: WR_EN at t updates the register at t+1. Writes to RO or unmapped addresses are silently ignored.
- WR_EN and RD_EN in the same cycle to the same address: the write is performed, and the read returns the pre-write value.
- Counters:
  - If cnt_en & iEVT[i]: EVT_CNT[i] += 1.
  - Saturates at all ones and holds; never wraps.
  - cnt_clr write: all counters = 0 next cycle. Clear wins over a same-cycle increment.
- INT_STATUS: a same-cycle W1C and new event on the same bit leaves the bit set (set wins).
- oINT registered: oINT(t+1) = |(INT_STATUS(t) & ~INT_MASK(t)).
- Reset mid-transaction: a pending RD_DATA_V is dropped; no response is owed after reset.
- No back-pressure; one transaction per cycle sustained.

Optional Feature:
- Macro: LINK_CH_REGS_CLR_ON_RD_EN.
- Defined: a read of EVT_CNT[i] returns the current value and clears that counter next cycle.
  - If iEVT[i] & cnt_en in the read cycle, the counter becomes 1, so no event is lost.
  - Saturated value is read, then cleared.
- Undefined: counters clear only via cnt_clr; reads are side-effect free.

Test Plan:
- Reset, read 0x00, 0x01, 0x04 -> RD_DATA_V exactly 1 cycle after each RD_EN. Data: ID_VAL, 0, 64'h00FF (NUM_EVT=8).
- Write SCRATCH=64'hA5A5_0123_4567_89AB, read back -> same value. Issue a simultaneous WR+RD with new value 1 -> the read returns the old value; a following read returns 1.
- Write CTRL=32'h0000_0103 -> oCTRL=32'h0000_0101; read CTRL -> 64'h101.
- CTRL=1, pulse iEVT[2] for 5 cycles, read 0x12 -> 5.
  - Force CNT_W=4 and pulse 20 times -> read 15.
  - Write cnt_clr -> read 0.
  - With CLR_ON_RD_EN: a second read -> 0; an event in the read cycle -> the next read returns 1.
- INT_MASK=0xFB, pulse iEVT[2] -> INT_STATUS=0x04 and oINT=1 two cycles after the event. W1C 0x04 with iEVT[2] in the same cycle -> status stays 0x04. W1C alone -> oINT=0.
- Read 0x100 and 0x2000 (unmapped) -> {32'hDEAD_BEEF,15'b0,ADDR}. A write to 0x100 leaves all registers unchanged. Assert rst_n low the cycle after RD_EN -> no RD_DATA_V.
